odometer_meas_ctrl: RTL
=======================

ODOMETER_MEAS_CTRL -- requirements
Module: odometer_meas_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYC, default 16: ring-oscillator settle time in CLK cycles, legal range 1..255.
REQ-002 SHALL have parameter DZ_W, default 10: deadzone timer width; timeout occurs at 2^DZ_W-1 CLK cycles in MEASURE.
REQ-003 SHALL have port CLK, input, 1: system clock; all logic on rising edge.
REQ-004 SHALL have port RESETB, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port START, input, 1: request one measurement; sampled only in IDLE.
REQ-006 SHALL have port ABORT, input, 1: cancel any measurement in progress.
REQ-007 SHALL have port DETECT, input, 1: beat-detect level, synchronous to CLK.
REQ-008 SHALL have port BF_COUNTER, input, 12: beat-frequency counter value.
REQ-009 SHALL have port RO_EN, output, 1: enables the stressed and reference oscillators.
REQ-010 SHALL have port CNT_CLR, output, 1: clears the beat-frequency counter.
REQ-011 SHALL have port CNT_EN, output, 1: enables the beat-frequency counter.
REQ-012 SHALL have port RESULT, output, 12: latched measurement value.
REQ-013 SHALL have port TIMEOUT, output, 1: the last measurement ended by deadzone timeout.
REQ-014 SHALL have port SCAN_OUT, output, 1: serial RESULT data, MSB first.
REQ-015 SHALL have port SCAN_VALID, output, 1: SCAN_OUT holds a valid bit.
REQ-016 SHALL have port BUSY, output, 1: high in every state except IDLE.
REQ-017 SHALL have port DONE, output, 1: one-cycle pulse marking measurement completion.

Function
REQ-018 SHALL implement states IDLE, CLEAR, SETTLE, MEASURE, CAPTURE, SHIFT, DONE.
REQ-019 SHALL move from IDLE to CLEAR when START=1, and SHALL ignore START in all other states.
REQ-020 SHALL stay in CLEAR for exactly 1 cycle with CNT_CLR=1, then enter SETTLE.
REQ-021 SHALL assert RO_EN throughout SETTLE, MEASURE and CAPTURE.
REQ-022 SHALL stay in SETTLE for exactly SETTLE_CYC cycles, then enter MEASURE.
REQ-023 SHALL assert CNT_EN and increment the deadzone timer each cycle in MEASURE, starting the timer from 0 on MEASURE entry.
REQ-024 SHALL define a DETECT falling edge as registered DETECT=1 with current DETECT=0; a falling edge SHALL be recognised only in MEASURE.
REQ-025 SHALL, on a DETECT falling edge in MEASURE, load RESULT with BF_COUNTER, clear TIMEOUT, and enter CAPTURE.
REQ-026 SHALL, when the deadzone timer reaches 2^DZ_W-1 in MEASURE, load RESULT with 12'hFFF, set TIMEOUT, and enter CAPTURE.
REQ-027 SHALL give timeout priority when a timeout and a DETECT falling edge occur in the same cycle.
REQ-028 SHALL stay in CAPTURE for 1 cycle with CNT_EN=0, then enter SHIFT.
REQ-029 SHALL stay in SHIFT for exactly 12 cycles with SCAN_VALID=1, driving RESULT[11] down to RESULT[0] on successive cycles, then enter DONE.
REQ-030 SHALL stay in DONE for 1 cycle with DONE=1, then return to IDLE.
REQ-031 SHALL, when ABORT=1 in any non-IDLE state, enter IDLE on the next cycle with RO_EN, CNT_EN, SCAN_VALID and DONE all 0.
REQ-032 SHALL keep RESULT and TIMEOUT unchanged on ABORT.
REQ-033 SHALL give ABORT priority over START, DETECT and timeout.
REQ-034 SHALL keep RESULT unchanged outside the capture event.
REQ-035 SHALL drive SCAN_OUT=0 when SCAN_VALID=0.

Reset
REQ-036 SHALL, while RESETB=0, force state IDLE, clear the deadzone timer, shift counter and registered DETECT, and hold all outputs at 0, including RESULT=12'h000.
REQ-037 SHALL, on reset mid-measurement, discard the measurement with no DONE pulse.
REQ-038 SHALL accept START on the first CLK edge after RESETB deasserts.

Structure
REQ-039 SHALL place the state enum, RESULT_W=12 and SAT_VAL=12'hFFF in shared package odometer_pkg.
REQ-040 SHALL implement the deadzone timer as one sub-module deadzone_timer with ports CLK, RESETB, CLR, EN, EXPIRED.

Verification (SETTLE_CYC=4, DZ_W=6)
REQ-041 SHALL cover normal capture: START pulse, BF_COUNTER=12'h2A5, DETECT falls after 20 MEASURE cycles -> RESULT=12'h2A5, TIMEOUT=0, 12 SCAN_VALID cycles carrying bits 0010_1010_0101 MSB first, then 1 DONE pulse.
REQ-042 SHALL cover timeout: DETECT held at 0 -> RESULT=12'hFFF and TIMEOUT=1 after 63 MEASURE cycles, followed by 12 scan ones.
REQ-043 SHALL cover simultaneous events: DETECT falls on timeout cycle 63 -> RESULT=12'hFFF, TIMEOUT=1.
REQ-044 SHALL cover abort: ABORT in MEASURE cycle 10 -> IDLE next cycle, RO_EN=0, no DONE pulse, prior RESULT retained.
REQ-045 SHALL cover busy START and early DETECT: START pulsed during SHIFT -> ignored, exactly one DONE pulse; DETECT falling edge during SETTLE -> no capture.
REQ-046 SHALL cover reset mid-measurement: RESETB low during SHIFT -> all outputs 0 immediately, then a new START completes normally.

Source files
------------

// File: rtl/odometer_pkg.sv
// Shared types and constants for the odometer measurement controller.
// Holds the FSM state encoding and the result width/saturation value.
package odometer_pkg;

  localparam int RESULT_W = 12;
  localparam logic [RESULT_W-1:0] SAT_VAL = 12'hFFF;

  // Wide enough for SETTLE_CYC up to 255 and for the 12 shift steps.
  localparam int STEP_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SETTLE,
    ST_MEASURE,
    ST_CAPTURE,
    ST_SHIFT,
    ST_DONE
  } meas_state_e;

  // The oscillators must keep running until the counter value is captured.
  function automatic logic ro_active(input meas_state_e s);
    return (s == ST_SETTLE) || (s == ST_MEASURE) || (s == ST_CAPTURE);
  endfunction

endpackage

// File: rtl/deadzone_timer.sv
// Deadzone timer: counts enabled cycles and flags the cycle whose increment
// brings the count to 2^W-1, so the timeout lands on enabled cycle 2^W-1.
module deadzone_timer #(
  parameter int W = 10
) (
  input  logic CLK,
  input  logic RESETB,
  input  logic CLR,
  input  logic EN,
  output logic EXPIRED
);

  localparam logic [W-1:0] LAST = {{(W-1){1'b1}}, 1'b0};

  logic [W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      count <= '0;
    end else if (CLR) begin
      count <= '0;
    end else if (EN) begin
      count <= count + 1'b1;
    end
  end

  assign EXPIRED = EN && (count == LAST);

endmodule

// File: rtl/odometer_meas_ctrl.sv
// Odometer measurement controller: sequences oscillator enable, beat counter
// clear/enable, capture on DETECT falling edge or deadzone timeout, and
// serial readout of the captured result.
module odometer_meas_ctrl
  import odometer_pkg::*;
#(
  parameter int SETTLE_CYC = 16,
  parameter int DZ_W       = 10
) (
  input  logic                CLK,
  input  logic                RESETB,
  input  logic                START,
  input  logic                ABORT,
  input  logic                DETECT,
  input  logic [RESULT_W-1:0] BF_COUNTER,
  output logic                RO_EN,
  output logic                CNT_CLR,
  output logic                CNT_EN,
  output logic [RESULT_W-1:0] RESULT,
  output logic                TIMEOUT,
  output logic                SCAN_OUT,
  output logic                SCAN_VALID,
  output logic                BUSY,
  output logic                DONE
);

  localparam logic [STEP_W-1:0] SETTLE_LAST = STEP_W'(SETTLE_CYC - 1);
  localparam logic [STEP_W-1:0] SHIFT_LAST  = STEP_W'(RESULT_W - 1);

  meas_state_e         state, state_next;
  logic [STEP_W-1:0]   step;
  logic                det_q;
  logic                det_fall;
  logic                dz_expired;
  logic                load_result;
  logic [RESULT_W-1:0] result_q, result_next;
  logic                timeout_q, timeout_next;
  logic [RESULT_W-1:0] scan_word;

  deadzone_timer #(
    .W(DZ_W)
  ) u_dz_timer (
    .CLK    (CLK),
    .RESETB (RESETB),
    .CLR    (state != ST_MEASURE),
    .EN     (state == ST_MEASURE),
    .EXPIRED(dz_expired)
  );

  assign det_fall = det_q && !DETECT;

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      state     <= ST_IDLE;
      step      <= '0;
      det_q     <= 1'b0;
      result_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state <= state_next;
      det_q <= DETECT;
      // Shared step counter restarts on every state change.
      if (state_next != state) begin
        step <= '0;
      end else if (state == ST_SETTLE || state == ST_SHIFT) begin
        step <= step + 1'b1;
      end
      if (load_result) begin
        result_q  <= result_next;
        timeout_q <= timeout_next;
      end
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_next   = state;
    load_result  = 1'b0;
    result_next  = result_q;
    timeout_next = timeout_q;

    if (state != ST_IDLE && ABORT) begin
      state_next = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE:    if (START) state_next = ST_CLEAR;
        ST_CLEAR:   state_next = ST_SETTLE;
        ST_SETTLE:  if (step == SETTLE_LAST) state_next = ST_MEASURE;
        ST_MEASURE: begin
          // Timeout wins over a coincident falling edge.
          if (dz_expired) begin
            state_next   = ST_CAPTURE;
            load_result  = 1'b1;
            result_next  = SAT_VAL;
            timeout_next = 1'b1;
          end else if (det_fall) begin
            state_next   = ST_CAPTURE;
            load_result  = 1'b1;
            result_next  = BF_COUNTER;
            timeout_next = 1'b0;
          end
        end
        ST_CAPTURE: state_next = ST_SHIFT;
        ST_SHIFT:   if (step == SHIFT_LAST) state_next = ST_DONE;
        ST_DONE:    state_next = ST_IDLE;
        default:    state_next = ST_IDLE;
      endcase
    end
  end

  assign scan_word = result_q << step[3:0];

  assign RO_EN      = ro_active(state);
  assign CNT_CLR    = (state == ST_CLEAR);
  assign CNT_EN     = (state == ST_MEASURE);
  assign SCAN_VALID = (state == ST_SHIFT);
  assign SCAN_OUT   = SCAN_VALID && scan_word[RESULT_W-1];
  assign BUSY       = (state != ST_IDLE);
  assign DONE       = (state == ST_DONE);
  assign RESULT     = result_q;
  assign TIMEOUT    = timeout_q;

endmodule
